// File: rtl/tff_count_ctrl.sv
// Sequencer for an external N-bit toggle-flop bank: clears it, loads a start value, then
// counts up/down between 0 and a latched limit, one-shot or auto-reload; T_EN is combinational.
module tff_count_ctrl #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_dir,
  input  logic         i_auto_reload,
  input  logic [N-1:0] i_limit,
  input  logic [N-1:0] i_q_fb,
  output logic [N-1:0] o_t_en,
  output logic         o_clr_n,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_wrap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic         r_dir;
  logic         r_auto;
  logic [N-1:0] r_limit;
  logic         r_clr_n;
  logic         r_busy;
  logic         r_done;
  logic         r_wrap;

  logic [N-1:0] w_start_val;
  logic [N-1:0] w_run_next;
  logic         w_term;

  always_comb begin
    w_start_val = r_dir ? '0 : r_limit;
    w_term      = r_dir ? (i_q_fb >= r_limit) : (i_q_fb == '0);
    if (r_dir) begin
      w_run_next = w_term ? '0 : (i_q_fb + C_ONE);
    end else begin
      // An out-of-range bank value in down mode is pulled back to the limit.
      w_run_next = ((i_q_fb == '0) || (i_q_fb > r_limit)) ? r_limit : (i_q_fb - C_ONE);
    end
  end

  always_comb begin
    o_t_en = '0;
    case (r_state)
      S_LOAD: if (!i_stop) o_t_en = i_q_fb ^ w_start_val;
      S_RUN:  if (!i_stop && (!w_term || r_auto)) o_t_en = i_q_fb ^ w_run_next;
      default: o_t_en = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_auto  <= 1'b0;
      r_limit <= '0;
      r_clr_n <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_clr_n <= 1'b1;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CLEAR;
            r_dir   <= i_dir;
            r_auto  <= i_auto_reload;
            r_limit <= i_limit;
            r_clr_n <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_term) begin
            if (r_auto) begin
              r_wrap <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_n = r_clr_n;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: models a 4-bit TFF bank and predicts every cycle
// from a count/age reference model driven by directed and random stimulus.
module tb_tff_count_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic         stop   = 1'b0;
  logic         dir    = 1'b0;
  logic         auto_r = 1'b0;
  logic [N-1:0] limit  = '0;
  logic [N-1:0] q_fb;
  logic [N-1:0] t_en;
  logic         clr_n, busy, done, wrap;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done_seen = 0;

  tff_count_ctrl #(.N(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_dir(dir),
    .i_auto_reload(auto_r), .i_limit(limit), .i_q_fb(q_fb), .o_t_en(t_en),
    .o_clr_n(clr_n), .o_busy(busy), .o_done(done), .o_wrap(wrap)
  );

  // The external toggle-flop bank with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q_fb <= '0;
    else        q_fb <= q_fb ^ t_en;
  end

  // Reference model: m_age counts cycles since an accepted START (1 = bank
  // being cleared, 2 = start value being loaded, 3+ = counting).
  bit m_run = 0, m_done = 0, m_busy = 0, m_wrap = 0, m_clrn = 0, m_dir = 0, m_auto = 0;
  int m_age = 0, m_lim = 0, m_q = 0;
  bit n_run, n_done, n_busy, n_wrap, n_clrn, n_dir, n_auto;
  int n_age, n_lim, n_q;
  int exp_t;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic predict();
    n_run = m_run; n_age = m_age; n_lim = m_lim; n_q = m_q; n_busy = m_busy;
    n_dir = m_dir; n_auto = m_auto;
    n_done = 0; n_wrap = 0; n_clrn = 1;
    if (rst) begin
      n_run = 0; n_age = 0; n_q = 0; n_clrn = 0; n_busy = 0;
    end else if (!m_run) begin
      if (start && !m_done) begin
        n_run = 1; n_age = 1; n_dir = dir; n_auto = auto_r; n_lim = int'(limit);
        n_q = 0; n_clrn = 0; n_busy = 1;
      end
    end else if (stop) begin
      n_run = 0; n_busy = 0;
    end else if (m_age == 1) begin
      n_age = 2;
    end else if (m_age == 2) begin
      n_age = 3;
      n_q = m_dir ? 0 : m_lim;
    end else if (m_dir ? (m_q >= m_lim) : (m_q == 0)) begin
      if (m_auto) begin
        n_q = m_dir ? 0 : m_lim;
        n_wrap = 1;
      end else begin
        n_run = 0; n_busy = 0; n_done = 1;
      end
    end else begin
      n_q = m_dir ? m_q + 1 : m_q - 1;
    end
    exp_t = (!m_run || m_age == 1) ? 0 : (n_q ^ m_q);
  endtask

  task automatic commit();
    m_run = n_run; m_age = n_age; m_lim = n_lim; m_q = n_q; m_busy = n_busy;
    m_dir = n_dir; m_auto = n_auto; m_done = n_done; m_wrap = n_wrap; m_clrn = n_clrn;
  endtask

  task automatic cycle(input int r, input int s, input int p, input int d, input int a,
                       input int l, input int stop_at, input int rst_at);
    int rr;
    int pp;
    rr = r;
    pp = p;
    @(negedge clk);
    check_eq("q_fb",  int'(q_fb),  m_q);
    check_eq("busy",  int'(busy),  int'(m_busy));
    check_eq("done",  int'(done),  int'(m_done));
    check_eq("wrap",  int'(wrap),  int'(m_wrap));
    check_eq("clr_n", int'(clr_n), int'(m_clrn));
    if (done) n_done_seen++;
    if (stop_at >= 0 && busy && int'(q_fb) == stop_at) pp = 1;
    if (rst_at >= 0 && busy && int'(q_fb) == rst_at) rr = 1;
    rst    = (rr != 0);
    start  = (s != 0);
    stop   = (pp != 0);
    dir    = (d != 0);
    auto_r = (a != 0);
    limit  = l[N-1:0];
    #1;
    predict();
    if (rr == 0) check_eq("t_en", int'(t_en), exp_t);
    @(posedge clk);
    commit();
  endtask

  task automatic rcyc(input int r, input int s, input int p);
    cycle(r, s, p, int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
          int'($urandom_range(15, 0)), -1, -1);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    m_run = 0; m_age = 0; m_q = 0; m_clrn = 0; m_busy = 0; m_done = 0; m_wrap = 0;
    cycle(1, 0, 0, 0, 0, 0, -1, -1);
    repeat (3) rcyc(0, 0, 0);

    // One-shot up to 5.
    n_done_seen = 0;
    cycle(0, 1, 0, 1, 0, 5, -1, -1);
    repeat (12) rcyc(0, 0, 0);
    #2;
    check_eq("t2_done_count", n_done_seen, 1);
    check_eq("t2_hold", int'(q_fb), 5);

    // Auto-reload down from 3, then abort.
    cycle(0, 1, 0, 0, 1, 3, -1, -1);
    repeat (14) rcyc(0, 0, 0);
    rcyc(0, 0, 1);
    rcyc(0, 0, 0);

    // Up to 9, stopped at 4.
    n_done_seen = 0;
    cycle(0, 1, 0, 1, 0, 9, -1, -1);
    repeat (10) cycle(0, 0, 0, int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                      int'($urandom_range(15, 0)), 4, -1);
    #2;
    check_eq("t4_hold", int'(q_fb), 4);
    check_eq("t4_busy", int'(busy), 0);
    check_eq("t4_no_done", n_done_seen, 0);

    // LIMIT=0 one-shot, then a START ignored during a LIMIT=15 run.
    n_done_seen = 0;
    cycle(0, 1, 0, 1, 0, 0, -1, -1);
    repeat (5) rcyc(0, 0, 0);
    check_eq("t5_done_count", n_done_seen, 1);
    cycle(0, 1, 0, 1, 0, 15, -1, -1);
    repeat (5) rcyc(0, 0, 0);
    cycle(0, 1, 0, 0, 1, 2, -1, -1);
    repeat (6) rcyc(0, 0, 0);
    rcyc(0, 0, 1);

    // Reset hit at count 7.
    cycle(0, 1, 0, 1, 1, 9, -1, -1);
    repeat (12) cycle(0, 0, 0, int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                      int'($urandom_range(15, 0)), -1, 7);
    #2;
    check_eq("t6_q_cleared", int'(q_fb), 0);
    check_eq("t6_busy", int'(busy), 0);

    // Random traffic, including up auto-reload with LIMIT=0.
    cycle(0, 1, 0, 1, 1, 0, -1, -1);
    repeat (8) rcyc(0, 0, 0);
    repeat (2000) cycle(int'(($urandom % 97) == 0), int'(($urandom % 5) == 0),
                        int'(($urandom % 37) == 0), int'($urandom_range(1, 0)),
                        int'($urandom_range(1, 0)), int'($urandom_range(15, 0)), -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
